// File: rtl/tape_player.sv
// tape_player - cassette playback generator feeding the machine's ear input.
//
// Converts a byte stream into a Lynx-style square-wave tape signal:
// a leader of 0-bit cycles, the sync byte, the data bytes (MSB first)
// and a trailing low gap. Each bit is one cycle of ear=1 for H ticks
// followed by ear=0 for H ticks, with H = HALF1 for a 1 and HALF0 for a 0.
//
// Optional feature macro: TAPE_PLAYER_MOTOR_EN
//   When defined, adds the `motor` input. While motor=0 nothing advances
//   (mid-bit freeze), and IDLE->LEADER also requires motor=1.
//
// Ports:
//   clock     - system clock
//   reset     - synchronous, active-high; aborts any state on the same edge
//   ce        - tick enable; all timing advances only on ce edges
//   play      - level; 1 starts or continues playback
//   byteValid - upstream has a byte on byteData
//   byteData  - data byte
//   byteLast  - byteData is the final byte of the block
//   byteReady - one-clock pulse after the edge on which a byte was taken
//   ear       - tape waveform
//   busy      - high in any state except IDLE
//   underrun  - sticky; DATA wanted a byte and none was valid
//   motor     - (TAPE_PLAYER_MOTOR_EN only) cassette motor enable

module tape_player #(
    parameter int unsigned HALF0  = 12,
    parameter int unsigned HALF1  = 24,
    parameter int unsigned LEADER = 768,
    parameter logic [7:0]  SYNCB  = 8'hA5,
    parameter int unsigned GAP    = 4800,
    parameter int unsigned CW     = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
`ifdef TAPE_PLAYER_MOTOR_EN
    input  logic       motor,
`endif
    input  logic       play,
    input  logic       byteValid,
    input  logic [7:0] byteData,
    input  logic       byteLast,
    output logic       byteReady,
    output logic       ear,
    output logic       busy,
    output logic       underrun
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SYNC,
        DATA,
        TAIL
    } state_t;

    localparam logic [CW-1:0] H0_END     = CW'(HALF0 - 1);
    localparam logic [CW-1:0] H1_END     = CW'(HALF1 - 1);
    localparam logic [CW-1:0] LEADER_END = CW'(LEADER - 1);
    localparam logic [CW-1:0] GAP_END    = CW'(GAP - 1);

    state_t        state;
    logic [CW-1:0] tick;       // ticks within the current half (or gap)
    logic [CW-1:0] cyc;        // leader cycle index
    logic          low_half;   // 0 = high half of the bit, 1 = low half
    logic [7:0]    shreg;      // byte being sent (sync or data)
    logic [2:0]    bit_idx;    // index into shreg of the bit being sent
    logic          have_byte;  // DATA: shreg holds a byte still being sent
    logic          last_byte;  // latched byteLast of the byte in shreg
    logic          stop;       // play was seen low during LEAD/SYNC/DATA

    logic          tick_en;
    logic          bit_now;
    logic [CW-1:0] half_end;
    logic          stopping;

`ifdef TAPE_PLAYER_MOTOR_EN
    assign tick_en = ce & motor;
`else
    assign tick_en = ce;
`endif

    assign busy     = (state != IDLE);
    assign stopping = stop | ~play;

    always_comb begin
        bit_now = 1'b0;
        if (state == SYNC || state == DATA)
            bit_now = shreg[bit_idx];
        half_end = bit_now ? H1_END : H0_END;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            tick      <= '0;
            cyc       <= '0;
            low_half  <= 1'b0;
            shreg     <= '0;
            bit_idx   <= '0;
            have_byte <= 1'b0;
            last_byte <= 1'b0;
            stop      <= 1'b0;
            ear       <= 1'b0;
            byteReady <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            byteReady <= 1'b0;
            if (tick_en) begin
                case (state)
                    IDLE: begin
                        if (play) begin
                            state     <= LEAD;
                            ear       <= 1'b1;
                            tick      <= '0;
                            low_half  <= 1'b0;
                            cyc       <= '0;
                            have_byte <= 1'b0;
                            stop      <= 1'b0;
                            underrun  <= 1'b0;
                        end
                    end

                    TAIL: begin
                        if (tick == GAP_END) begin
                            state <= IDLE;
                            tick  <= '0;
                        end else begin
                            tick <= tick + CW'(1);
                        end
                    end

                    LEAD, SYNC, DATA: begin
                        if (!play)
                            stop <= 1'b1;

                        if (state == DATA && !have_byte) begin
                            // Shifter empty: either leave, take a byte, or stall
                            if (stopping) begin
                                state <= TAIL;
                                tick  <= '0;
                                ear   <= 1'b0;
                            end else if (byteValid) begin
                                byteReady <= 1'b1;
                                shreg     <= byteData;
                                last_byte <= byteLast;
                                have_byte <= 1'b1;
                                bit_idx   <= 3'd7;
                                tick      <= '0;
                                low_half  <= 1'b0;
                                ear       <= 1'b1;
                            end else begin
                                underrun <= 1'b1;
                            end
                        end else if (tick != half_end) begin
                            tick <= tick + CW'(1);
                        end else if (!low_half) begin
                            low_half <= 1'b1;
                            tick     <= '0;
                            ear      <= 1'b0;
                        end else begin
                            // Bit cycle complete: next bit starts on this edge
                            tick     <= '0;
                            low_half <= 1'b0;
                            if (stopping) begin
                                state <= TAIL;
                                ear   <= 1'b0;
                            end else begin
                                case (state)
                                    LEAD: begin
                                        ear <= 1'b1;
                                        if (cyc == LEADER_END) begin
                                            state   <= SYNC;
                                            shreg   <= SYNCB;
                                            bit_idx <= 3'd7;
                                        end else begin
                                            cyc <= cyc + CW'(1);
                                        end
                                    end
                                    SYNC: begin
                                        if (bit_idx == 3'd0) begin
                                            state <= DATA;
                                            // Fetch on the same edge so the first data bit has no idle tick
                                            if (byteValid) begin
                                                byteReady <= 1'b1;
                                                shreg     <= byteData;
                                                last_byte <= byteLast;
                                                have_byte <= 1'b1;
                                                bit_idx   <= 3'd7;
                                                ear       <= 1'b1;
                                            end else begin
                                                have_byte <= 1'b0;
                                                underrun  <= 1'b1;
                                                ear       <= 1'b0;
                                            end
                                        end else begin
                                            bit_idx <= bit_idx - 3'd1;
                                            ear     <= 1'b1;
                                        end
                                    end
                                    default: begin // DATA
                                        if (bit_idx != 3'd0) begin
                                            bit_idx <= bit_idx - 3'd1;
                                            ear     <= 1'b1;
                                        end else if (last_byte) begin
                                            state     <= TAIL;
                                            have_byte <= 1'b0;
                                            ear       <= 1'b0;
                                        end else if (byteValid) begin
                                            byteReady <= 1'b1;
                                            shreg     <= byteData;
                                            last_byte <= byteLast;
                                            have_byte <= 1'b1;
                                            bit_idx   <= 3'd7;
                                            ear       <= 1'b1;
                                        end else begin
                                            have_byte <= 1'b0;
                                            underrun  <= 1'b1;
                                            ear       <= 1'b0;
                                        end
                                    end
                                endcase
                            end
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
